// File: rtl/joy_db9_pkg.sv
// Shared types and default sizing for the DB9 joystick chain scanner.
// Default constants match the NeptUNO+ middleboard wiring.
package joy_db9_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        SHIFT,
        DONE
    } joy_state_t;

    localparam int JOY_BITS_DEF     = 12;
    localparam int CLK_DIV_DEF      = 8;
    localparam int FRAME_CYCLES_DEF = 50000;

endpackage

// File: rtl/joy_db9_sync.sv
// Two-flop synchronizer for the chain's serial output.
// Resets high because the chain idles high.
module joy_db9_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ff_q <= 2'b11;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/joy_db9_scanner.sv
// DB9 joystick chain scanner: drives JOY_LOAD/JOY_CLK, deserializes JOY_DATA.
// Define JOY_DB9_DEBOUNCE_EN to publish a frame only when two in a row agree.
module joy_db9_scanner
    import joy_db9_pkg::*;
#(
    parameter int CLK_DIV      = CLK_DIV_DEF,
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int JOY_BITS     = JOY_BITS_DEF
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                scan_en,
    input  logic                JOY_DATA,
    output logic                JOY_CLK,
    output logic                JOY_LOAD,
    output logic [JOY_BITS-1:0] joy1,
    output logic [JOY_BITS-1:0] joy2,
    output logic                frame_valid,
    output logic                busy
);

    localparam int NB = 2 * JOY_BITS;
    localparam int TW = $clog2(FRAME_CYCLES);
    localparam int PW = $clog2(CLK_DIV);
    localparam int BW = $clog2(NB);

    localparam logic [TW-1:0] T_LAST = TW'(FRAME_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NB - 1);

    joy_state_t          state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [PW-1:0]       ph_q, ph_d;
    logic                hi_q, hi_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [NB-1:0]       sr_q, sr_d;
    logic [JOY_BITS-1:0] joy1_q, joy1_d;
    logic [JOY_BITS-1:0] joy2_q, joy2_d;
    logic                fv_q, fv_d;
    logic                jclk_q, jclk_d;
    logic                jload_q, jload_d;
    logic                busy_q, busy_d;
    logic                data_s;
    logic                ph_end;
`ifdef JOY_DB9_DEBOUNCE_EN
    logic [NB-1:0]       prev_q, prev_d;
`endif

    joy_db9_sync u_sync (
        .clk_i  (clk_sys),
        .rst_ni (reset_n),
        .d_i    (JOY_DATA),
        .q_o    (data_s)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            ph_q    <= '0;
            hi_q    <= 1'b0;
            bit_q   <= '0;
            sr_q    <= '1;
            joy1_q  <= '0;
            joy2_q  <= '0;
            fv_q    <= 1'b0;
            jclk_q  <= 1'b1;
            jload_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef JOY_DB9_DEBOUNCE_EN
            prev_q  <= '1;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ph_q    <= ph_d;
            hi_q    <= hi_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            joy1_q  <= joy1_d;
            joy2_q  <= joy2_d;
            fv_q    <= fv_d;
            jclk_q  <= jclk_d;
            jload_q <= jload_d;
            busy_q  <= busy_d;
`ifdef JOY_DB9_DEBOUNCE_EN
            prev_q  <= prev_d;
`endif
        end
    end

    assign ph_end = (ph_q == P_LAST);

    // The timer free-runs through frames so frame starts stay FRAME_CYCLES apart.
    always_comb begin
        state_d = state_q;
        timer_d = (timer_q == T_LAST) ? '0 : timer_q + TW'(1);
        ph_d    = ph_q;
        hi_d    = hi_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        unique case (state_q)
            IDLE: begin
                ph_d  = '0;
                hi_d  = 1'b0;
                bit_d = '0;
                if (timer_q == T_LAST && scan_en) begin
                    state_d = LOAD;
                end
            end
            LOAD, SETUP: begin
                if (ph_end) begin
                    ph_d    = '0;
                    hi_d    = 1'b0;
                    bit_d   = '0;
                    state_d = (state_q == LOAD) ? SETUP : SHIFT;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            SHIFT: begin
                if (!ph_end) begin
                    ph_d = ph_q + PW'(1);
                end else begin
                    ph_d = '0;
                    if (!hi_q) begin
                        hi_d = 1'b1;
                        sr_d = {sr_q[NB-2:0], data_s};
                    end else begin
                        hi_d = 1'b0;
                        if (bit_q == B_LAST) begin
                            state_d = DONE;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        jload_d = (state_d != LOAD);
        jclk_d  = !(state_d == SHIFT && !hi_d);
        busy_d  = (state_d != IDLE);
        joy1_d  = joy1_q;
        joy2_d  = joy2_q;
        fv_d    = 1'b0;
`ifdef JOY_DB9_DEBOUNCE_EN
        prev_d  = prev_q;
        if (state_q == DONE) begin
            prev_d = sr_q;
            if (sr_q == prev_q) begin
                joy1_d = ~sr_q[NB-1:JOY_BITS];
                joy2_d = ~sr_q[JOY_BITS-1:0];
                fv_d   = 1'b1;
            end
        end
`else
        if (state_q == DONE) begin
            joy1_d = ~sr_q[NB-1:JOY_BITS];
            joy2_d = ~sr_q[JOY_BITS-1:0];
            fv_d   = 1'b1;
        end
`endif
    end

    assign JOY_CLK     = jclk_q;
    assign JOY_LOAD    = jload_q;
    assign joy1        = joy1_q;
    assign joy2        = joy2_q;
    assign frame_valid = fv_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_joy_db9_scanner.sv
// Bench for joy_db9_scanner with a behavioural 24-bit PISO chain model.
// Expectations follow JOY_DB9_DEBOUNCE_EN when it is defined.
module tb_joy_db9_scanner;

    localparam int CD = 4;
    localparam int FC = 1000;
    localparam int JB = 12;

    logic          clk_sys  = 1'b0;
    logic          reset_n  = 1'b0;
    logic          scan_en  = 1'b0;
    logic          JOY_DATA = 1'b1;
    logic          JOY_CLK;
    logic          JOY_LOAD;
    logic [JB-1:0] joy1;
    logic [JB-1:0] joy2;
    logic          frame_valid;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    logic [23:0] pat   = '1;
    logic [23:0] chain = '1;
    logic [11:0] cur_j1 = '0;
    logic [11:0] cur_j2 = '0;

    typedef struct {
        logic [23:0] raw;
        logic [11:0] j1;
        logic [11:0] j2;
    } vec_t;
    vec_t vecs[6];

    joy_db9_scanner #(
        .CLK_DIV      (CD),
        .FRAME_CYCLES (FC),
        .JOY_BITS     (JB)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .scan_en     (scan_en),
        .JOY_DATA    (JOY_DATA),
        .JOY_CLK     (JOY_CLK),
        .JOY_LOAD    (JOY_LOAD),
        .joy1        (joy1),
        .joy2        (joy2),
        .frame_valid (frame_valid),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Chain: parallel load on JOY_LOAD fall, MSB out first, shifts 1 ns after JOY_CLK rise.
    always @(negedge JOY_LOAD or posedge JOY_CLK) begin
        if (!JOY_LOAD) begin
            chain = pat;
            JOY_DATA = chain[23];
        end else begin
            #1;
            chain = {chain[22:0], 1'b1};
            JOY_DATA = chain[23];
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input logic [23:0] p, input int drop_at,
                             output int load_c, output int rises,
                             output int fvs, output int start_c, output bit tmo);
        bit   started;
        logic pclk;
        logic pbusy;
        started = 1'b0;
        pclk    = 1'b1;
        pbusy   = 1'b0;
        pat     = p;
        load_c  = 0;
        rises   = 0;
        fvs     = 0;
        start_c = -1;
        tmo     = 1'b1;
        for (int i = 0; i < 3 * FC; i++) begin
            @(negedge clk_sys);
            if (!started && !JOY_LOAD) begin
                started = 1'b1;
                start_c = cyc;
            end
            if (started) begin
                if (!JOY_LOAD) load_c++;
                if (JOY_CLK && !pclk) begin
                    rises++;
                    if (rises == drop_at) scan_en = 1'b0;
                end
                if (frame_valid) fvs++;
                if (pbusy && !busy) begin
                    tmo = 1'b0;
                    break;
                end
            end
            pclk  = JOY_CLK;
            pbusy = busy;
        end
    endtask

    task automatic do_vec(input logic [23:0] raw, input int drop_at, output int first_start);
        int l, r, f, s;
        bit t;
        logic [11:0] e1, e2;
        e1 = ~raw[23:12];
        e2 = ~raw[11:0];
`ifdef JOY_DB9_DEBOUNCE_EN
        run_frame(raw, -1, l, r, f, s, t);
        first_start = s;
        chk("db_first_timeout", t, 0);
        chk("db_first_fv", f, 0);
        chk("db_first_joy1_hold", joy1, cur_j1);
        chk("db_first_joy2_hold", joy2, cur_j2);
        run_frame(raw, drop_at, l, r, f, s, t);
`else
        run_frame(raw, drop_at, l, r, f, s, t);
        first_start = s;
`endif
        chk("frame_timeout", t, 0);
        chk("frame_valid_pulses", f, 1);
        chk("clk_rises", r, 24);
        chk("load_len", l, CD);
        chk("frame_period", s % FC, 0);
        chk("joy1", joy1, e1);
        chk("joy2", joy2, e2);
        cur_j1 = e1;
        cur_j2 = e2;
    endtask

    initial begin
        int   fs, l, r, f, s, pulses;
        bit   t, bad;
        logic [23:0] rp;

        vecs[0] = '{24'hFFFFFF, 12'h000, 12'h000};
        vecs[1] = '{24'h000000, 12'hFFF, 12'hFFF};
        vecs[2] = '{24'hA5A5A5, 12'h5A5, 12'hA5A};
        vecs[3] = '{24'h123456, 12'hEDC, 12'hBA9};
        vecs[4] = '{24'h800001, 12'h7FF, 12'hFFE};
        vecs[5] = '{24'h5A5A5A, 12'hA5A, 12'h5A5};

        // Reset values and first frame timing
        scan_en = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("rst_joy_clk", JOY_CLK, 1);
        chk("rst_joy_load", JOY_LOAD, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_joy1", joy1, 0);
        chk("rst_joy2", joy2, 0);
        reset_n = 1'b1;
        bad = 1'b0;
        for (int k = 1; k < FC; k++) begin
            @(negedge clk_sys);
            if (!JOY_LOAD || busy || frame_valid) bad = 1'b1;
        end
        chk("no_early_load", bad, 0);
        do_vec(24'h0FFFFE, -1, fs);
        chk("first_load_cycle", fs, FC);

        for (int i = 0; i < 6; i++) begin
            do_vec(vecs[i].raw, -1, fs);
        end

        // scan_en dropped during SHIFT bit 5
        do_vec(24'h3C3C3C, 6, fs);
        bad = 1'b0;
        for (int k = 0; k < 3 * FC; k++) begin
            @(negedge clk_sys);
            if (!JOY_LOAD || busy) bad = 1'b1;
        end
        chk("no_load_while_disabled", bad, 0);
        scan_en = 1'b1;
        s = cyc;
        do_vec(24'hC3C3C3, -1, fs);
        chk("resume_within_period", (fs - s) <= FC, 1);

        // Reset during SHIFT bit 10
        pat = 24'h00FF00;
        r = 0;
        t = 1'b1;
        l = 1;
        for (int k = 0; k < 3 * FC; k++) begin
            @(negedge clk_sys);
            if (JOY_CLK && !l[0]) r++;
            l = {31'd0, JOY_CLK};
            if (r == 11) begin
                t = 1'b0;
                break;
            end
        end
        chk("midreset_reach_bit10", t, 0);
        reset_n = 1'b0;
        @(negedge clk_sys);
        chk("midrst_joy_clk", JOY_CLK, 1);
        chk("midrst_joy_load", JOY_LOAD, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_joy1", joy1, 0);
        chk("midrst_joy2", joy2, 0);
        cur_j1 = '0;
        cur_j2 = '0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        do_vec(24'h96C3E1, -1, fs);
        chk("post_reset_load_cycle", fs, FC);

        // Raw A, B, B sequence
        pulses = 0;
        run_frame(24'h111111, -1, l, r, f, s, t);
        chk("abb_a_timeout", t, 0);
        pulses += f;
`ifdef JOY_DB9_DEBOUNCE_EN
        chk("abb_a_fv", f, 0);
        chk("abb_a_joy1", joy1, cur_j1);
`else
        chk("abb_a_fv", f, 1);
        chk("abb_a_joy1", joy1, 12'hEEE);
`endif
        run_frame(24'h222222, -1, l, r, f, s, t);
        chk("abb_b1_timeout", t, 0);
        pulses += f;
`ifdef JOY_DB9_DEBOUNCE_EN
        chk("abb_b1_fv", f, 0);
        chk("abb_b1_joy2", joy2, cur_j2);
`else
        chk("abb_b1_fv", f, 1);
        chk("abb_b1_joy2", joy2, 12'hDDD);
`endif
        run_frame(24'h222222, -1, l, r, f, s, t);
        chk("abb_b2_timeout", t, 0);
        pulses += f;
        chk("abb_b2_fv", f, 1);
        chk("abb_b2_joy1", joy1, 12'hDDD);
        chk("abb_b2_joy2", joy2, 12'hDDD);
`ifdef JOY_DB9_DEBOUNCE_EN
        chk("abb_total_pulses", pulses, 1);
`else
        chk("abb_total_pulses", pulses, 3);
`endif
        cur_j1 = 12'hDDD;
        cur_j2 = 12'hDDD;

        // Random frames, data changing 1 ns after each JOY_CLK rise
        for (int i = 0; i < 25; i++) begin
            rp = 24'($urandom);
            if (rp == 24'h222222) rp = 24'h123123;
            do_vec(rp, -1, fs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
